// File: rtl/filter_window_gen_5x5_if.sv
// Pixel-stream in / 5x5 window out bundle for the window generator.
interface filter_window_gen_5x5_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      i_valid;
  logic                      i_sof;
  logic [DATA_WIDTH-1:0]     i_data;
  logic                      o_en;
  logic                      o_last;
  logic [25*DATA_WIDTH-1:0]  o_win;

  modport master (output i_valid, i_sof, i_data, input o_en, o_last, o_win);
  modport slave  (input i_valid, i_sof, i_data, output o_en, o_last, o_win);
endinterface

// File: rtl/filter_window_gen_5x5.sv
// Raster pixel stream to 5x5 window generator: four line buffers feed a 5x5
// shift array; a window is emitted only when it lies fully inside the frame.
module filter_window_gen_5x5 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480
) (
  input  logic                   clk,
  input  logic                   rstn,
  filter_window_gen_5x5_if.slave bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WIN_W = 25 * DATA_WIDTH;

  logic [COL_W-1:0]      col, cur_col;
  logic [ROW_W-1:0]      row, cur_row;
  logic [DATA_WIDTH-1:0] lb      [4][IMG_W];
  logic [DATA_WIDTH-1:0] col_vec [5];
  logic [DATA_WIDTH-1:0] sa      [5][5];
  logic [DATA_WIDTH-1:0] sa_nxt  [5][5];
  logic [WIN_W-1:0]      win_nxt;
  logic                  win_ok_c;
  logic                  frame_end_c;
  logic                  line_end_c;

  // Position of the current pixel (sof forces 0,0), column vector and next array
  always_comb begin
    cur_col = bus.i_sof ? '0 : col;
    cur_row = bus.i_sof ? '0 : row;

    col_vec[0] = lb[3][cur_col];
    col_vec[1] = lb[2][cur_col];
    col_vec[2] = lb[1][cur_col];
    col_vec[3] = lb[0][cur_col];
    col_vec[4] = bus.i_data;

    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        sa_nxt[r][c] = sa[r][c+1];
      end
      sa_nxt[r][4] = col_vec[r];
    end

    win_nxt = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_nxt[(5*r+c)*DATA_WIDTH +: DATA_WIDTH] = sa_nxt[r][c];
      end
    end

    line_end_c  = (cur_col == COL_W'(IMG_W - 1));
    frame_end_c = line_end_c && (cur_row == ROW_W'(IMG_H - 1));
    win_ok_c    = bus.i_valid && (cur_row >= ROW_W'(4)) && (cur_col >= COL_W'(4));
  end

  // Raster counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (bus.i_valid) begin
      if (frame_end_c) begin
        col <= '0;
        row <= '0;
      end else if (line_end_c) begin
        col <= '0;
        row <= cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers: read-before-write at the same column, deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.i_valid) begin
      lb[3][cur_col] <= lb[2][cur_col];
      lb[2][cur_col] <= lb[1][cur_col];
      lb[1][cur_col] <= lb[0][cur_col];
      lb[0][cur_col] <= bus.i_data;
    end
  end

  // 5x5 shift array; new column enters at column 4
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          sa[r][c] <= '0;
        end
      end
    end else if (bus.i_valid) begin
      sa <= sa_nxt;
    end
  end

  // Registered window outputs; o_win holds between pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_en   <= 1'b0;
      bus.o_last <= 1'b0;
      bus.o_win  <= '0;
    end else begin
      bus.o_en   <= win_ok_c;
      bus.o_last <= win_ok_c && frame_end_c;
      if (win_ok_c) begin
        bus.o_win <= win_nxt;
      end
    end
  end

endmodule
